// File: rtl/signed_search_ctrl_if.sv
// ---------------------------------------------------------------------------
// signed_search_ctrl_if
//
// Purpose:
//   Bundles the signals between the signed search controller and its
//   environment: the start request, the three comparator flags, and the
//   search outputs (probe value, status and result).
//
// Signals:
//   start   1       begin a search (sampled only while the controller idles)
//   AgtB    1       comparator flag: guess > secret (signed)
//   AeqB    1       comparator flag: guess == secret
//   AltB    1       comparator flag: guess < secret (signed)
//   guess   WIDTH   registered probe value, wired to comparator A
//   busy    1       search in progress
//   done    1       one-cycle pulse at search end
//   found   1       secret located (valid with done, held afterwards)
//   error   1       flags were not one-hot (valid with done, held afterwards)
//   result  WIDTH   located value, held until the next accepted start
//   steps   STEP_W  number of evaluation cycles in the last search
//
// Modports:
//   master  the search controller
//   slave   the requester / comparator side
// ---------------------------------------------------------------------------
interface signed_search_ctrl_if #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 4
);
    logic              start;
    logic              AgtB;
    logic              AeqB;
    logic              AltB;
    logic [WIDTH-1:0]  guess;
    logic              busy;
    logic              done;
    logic              found;
    logic              error;
    logic [WIDTH-1:0]  result;
    logic [STEP_W-1:0] steps;

    // The controller consumes start and the flags and produces everything else
    modport master (
        input  start, AgtB, AeqB, AltB,
        output guess, busy, done, found, error, result, steps
    );

    // The environment issues start, answers with flags and observes the outputs
    modport slave (
        output start, AgtB, AeqB, AltB,
        input  guess, busy, done, found, error, result, steps
    );
endinterface

// File: rtl/signed_search_ctrl.sv
// ---------------------------------------------------------------------------
// signed_search_ctrl
//
// Purpose:
//   Sequential initiator for a signed magnitude comparator. It drives the
//   comparator's A operand with successive guesses, reads back the
//   AgtB/AeqB/AltB flags and binary-searches the signed WIDTH-bit range to
//   recover the unknown operand presented on comparator input B.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous, active-high reset
//   io_bus  master modport of signed_search_ctrl_if
//           (start and flags in; guess, busy, done, found, error,
//            result, steps out)
//
// Each probe takes two cycles: CALC registers the new guess, EVAL samples
// the flags one full cycle later, so done appears 2*steps edges after the
// edge that accepted start. At most WIDTH+1 probes are ever needed.
// ---------------------------------------------------------------------------
module signed_search_ctrl #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 4
) (
    input logic                  clk,
    input logic                  reset,
    signed_search_ctrl_if.master io_bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_EVAL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Bounds carry one extra bit so guess-1 / guess+1 never wrap at the
    // extremes of the WIDTH-bit range.
    localparam logic signed [WIDTH:0] LO_INIT = {2'b11, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH:0] HI_INIT = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0] ONE     = 1;

    logic [1:0]               r_state;
    logic signed [WIDTH:0]    r_lo;
    logic signed [WIDTH:0]    r_hi;
    logic [WIDTH-1:0]         r_guess;
    logic [WIDTH-1:0]         r_result;
    logic [STEP_W-1:0]        r_steps;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_found;
    logic                     r_error;

    logic signed [WIDTH+1:0]  w_sum;
    logic signed [WIDTH:0]    w_guessExt;
    logic signed [WIDTH:0]    w_guessDec;
    logic signed [WIDTH:0]    w_guessInc;
    logic [2:0]               w_flags;

    // lo+hi is formed one bit wider still so the midpoint sum cannot
    // overflow; the arithmetic shift then floors toward -inf.
    assign w_sum      = $signed({r_lo[WIDTH], r_lo}) + $signed({r_hi[WIDTH], r_hi});
    assign w_guessExt = $signed({r_guess[WIDTH-1], r_guess});
    assign w_guessDec = w_guessExt - ONE;
    assign w_guessInc = w_guessExt + ONE;
    assign w_flags    = {io_bus.AgtB, io_bus.AeqB, io_bus.AltB};

    // Search state machine. done and busy change on the edge that enters
    // DONE, so the done pulse lines up with the DONE state cycle. A start
    // request is only looked at in IDLE; anything else ignores it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_lo     <= '0;
            r_hi     <= '0;
            r_guess  <= '0;
            r_result <= '0;
            r_steps  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        r_lo    <= LO_INIT;
                        r_hi    <= HI_INIT;
                        r_steps <= '0;
                        r_found <= 1'b0;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_guess <= WIDTH'(w_sum >>> 1);
                    r_state <= S_EVAL;
                end
                S_EVAL: begin
                    r_steps <= r_steps + STEP_W'(1);
                    case (w_flags)
                        3'b010: begin
                            r_result <= r_guess;
                            r_found  <= 1'b1;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= S_DONE;
                        end
                        3'b100: begin
                            r_hi <= w_guessDec;
                            if (r_lo > w_guessDec) begin
                                r_found <= 1'b0;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_CALC;
                            end
                        end
                        3'b001: begin
                            r_lo <= w_guessInc;
                            if (w_guessInc > r_hi) begin
                                r_found <= 1'b0;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_CALC;
                            end
                        end
                        default: begin
                            // No flag or several flags: the comparator path is broken
                            r_error <= 1'b1;
                            r_found <= 1'b0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end
                    endcase
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.guess  = r_guess;
    assign io_bus.busy   = r_busy;
    assign io_bus.done   = r_done;
    assign io_bus.found  = r_found;
    assign io_bus.error  = r_error;
    assign io_bus.result = r_result;
    assign io_bus.steps  = r_steps;

endmodule

// File: doc/signed_search_ctrl.md
Name: signed_search_ctrl

Overview:
- Sequential initiator for the signed magnitude comparator.
- Drives the comparator's A operand with successive guesses and reads back its AgtB/AeqB/AltB flags.
- Binary-searches the signed WIDTH-bit range to recover the unknown operand on comparator input B.
- Used where a value is only observable through compare results, for example threshold search and self-test of the comparator path.

Parameters:
- WIDTH, 4, operand width; two's complement, range -2^(WIDTH-1) .. 2^(WIDTH-1)-1.
- STEP_W, 4, width of the probe counter; must hold WIDTH+1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a search; sampled only in IDLE.
- AgtB  in  1  comparator flag: guess > secret (signed).
- AeqB  in  1  comparator flag: guess == secret.
- AltB  in  1  comparator flag: guess < secret (signed).
- guess  out  WIDTH  registered probe value; wired to comparator A.
- busy  out  1  high from the cycle after start is accepted until DONE is entered.
- done  out  1  one-cycle pulse at search end.
- found  out  1  valid with done and held after it; 1 = secret located.
- error  out  1  valid with done and held after it; 1 = flags were not one-hot.
- result  out  WIDTH  located value; held until the next accepted start.
- steps  out  STEP_W  number of EVAL cycles in the last search; held.

Behaviour:
- Reset (async, any state, including mid-search):
  - State goes to IDLE.
  - guess, result, steps = 0; busy, done, found, error = 0.
  - Internal bounds lo/hi are cleared.
- Internal bounds lo and hi are signed WIDTH+1 bits, so guess±1 never wraps.
- mid = (lo+hi) >>> 1: arithmetic shift, floor toward -inf.
- States:
  - IDLE: start=1 → lo = -2^(WIDTH-1), hi = 2^(WIDTH-1)-1; steps, found, error = 0; busy = 1; go to CALC. start=0 → stay.
  - CALC: guess <= mid[WIDTH-1:0]; go to EVAL. guess is stable for one full cycle before it is sampled.
  - EVAL: steps += 1, then sample the flags.
    - Exactly AeqB → result = guess, found = 1; go to DONE.
    - Exactly AgtB → hi = guess-1.
    - Exactly AltB → lo = guess+1.
    - After an AgtB/AltB update: new lo > new hi → found = 0 (range exhausted), go to DONE; otherwise go to CALC.
    - Flags not one-hot (none set, or more than one) → error = 1, found = 0; go to DONE.
  - DONE: done = 1 for this one cycle; busy = 0; go to IDLE.
- Timing:
  - done is high in the cycle starting at edge 2*steps after the start-sampling edge.
  - Maximum steps = WIDTH+1 (5 for WIDTH=4).
- start asserted while not in IDLE, including in DONE, is ignored. There is no queuing.
- guess keeps its last value after the search, so comparator A stays stable.
- The secret on comparator B must be stable from start until done. Changes during a search give undefined results but the block still terminates within WIDTH+1 probes.
- result is not updated when found=0.

Test Plan:
1. secret=-1, start pulse → guess sequence -1; found=1, result=-1, steps=1; done 2 edges after start edge.
2. secret=-8 → guesses -1, -5, -7, -8; found=1, result=-8, steps=4.
3. secret=7 → guesses -1, 3, 5, 6, 7; found=1, result=7, steps=5; done 10 edges after start edge.
4. secret=0 → guesses -1, 3, 1, 0; found=1, steps=4. Then secret=2 with a second start → result=2. start held high through DONE does not retrigger until IDLE is reached.
5. Flag fault: force AgtB=AltB=1 on the first EVAL → error=1, found=0, steps=1, result unchanged. Force all flags 0 → same response.
6. Assert reset during the third EVAL of a secret=-8 search → all outputs 0, state IDLE. A fresh start then completes with result=-8, steps=4.
